// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and the IF/ID register payload type
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Bubble: MIPS nop (sll $0,$0,0) with no PC and valid clear
  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register; squash beats load, otherwise holds
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   squash,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_BUBBLE;
    end else if (squash) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, next-PC selection, IF/ID capture
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] PC_INIT  = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        in_range;
  logic        load;
  logic        squash;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign imem_addr      = pc;
  assign pc_plus4       = pc + PC_STEP;
  assign target_aligned = redirect_target & 32'hFFFF_FFFC;
  assign in_range       = (pc < PC_LIMIT);

  // Redirect overrides stall; an out-of-range PC bubbles instead of fetching
  assign load    = !redirect && !stall && in_range;
  assign squash  = redirect || (!stall && !in_range);
  assign if_id_d = '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= PC_INIT;
      fetch_fault <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= target_aligned;
      end else if (load) begin
        pc <= pc_plus4;
      end
      if (!redirect && !stall && !in_range) begin
        fetch_fault <= 1'b1;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .squash (squash),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stalls  <= 32'h0;
    end else begin
      if (load) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall && !redirect) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS single-issue pipeline. Owns the program counter and drives the word address into `instruction_memory`, whose read is combinational. Captures the returned instruction and PC+4 into the IF/ID pipeline register consumed by decode. Handles stall (hold) and redirect (taken branch/jump: reload PC and squash the in-flight fetch).

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_WORDS`, 64: words backed by instruction memory; fetches at or above `IMEM_WORDS*4` are out of range.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: decode/hazard unit requests hold; PC and IF/ID keep their values.
- `redirect`  in  1: taken branch/jump from a later stage.
- `redirect_target`  in  32: new PC; bits [1:0] ignored and forced to 0.
- `imem_addr`  out  32: byte address to instruction memory; equals the PC register.
- `imem_instr`  in  32: instruction word returned combinationally for `imem_addr`.
- `if_id_instr`  out  32: registered instruction to decode.
- `if_id_pc_plus4`  out  32: registered PC+4 of that instruction.
- `if_id_valid`  out  1: IF/ID holds a real instruction; 0 means bubble.
- `fetch_fault`  out  1: sticky; set on the first out-of-range fetch.

## Operation
- PC register, reset `RESET_PC`. Word aligned at all times; bits [1:0] always 0.
- `imem_addr` = PC, with no register between them. `imem_instr` is sampled at the same edge that advances the PC.
- Per rising edge, priority highest first:
  - `redirect` = 1: PC ← {`redirect_target`[31:2], 2'b00}. IF/ID ← bubble (`instr` = 32'h0, `valid` = 0, `pc_plus4` = 0). This applies even when `stall` = 1: redirect overrides stall.
  - `stall` = 1: PC and IF/ID unchanged.
  - PC out of range (PC ≥ `IMEM_WORDS*4`): IF/ID ← bubble. PC holds, so fetch does not run off the end. `fetch_fault` ← 1.
  - Otherwise: IF/ID ← {`imem_instr`, PC+4, 1}, and PC ← PC+4.
- PC+4 is 32-bit modulo arithmetic; 32'hFFFF_FFFC + 4 wraps to 0. That PC is out of range anyway, so the hold rule applies first.
- `fetch_fault` clears only on reset. A redirect back in range resumes fetching but does not clear the flag.
- Bubble encoding 32'h0 is the MIPS nop (`sll $0,$0,0`). Decode may ignore `valid`, but the bench must check it.

## Timing
- Reset (async assert, any time, including mid-stall or mid-redirect) gives immediately: PC = `RESET_PC`, `if_id_instr` = 0, `if_id_pc_plus4` = 0, `if_id_valid` = 0, `fetch_fault` = 0. Release is synchronous to `clk` by the system reset synchronizer.
- Fetch latency: 1 cycle. The instruction at PC appears on `if_id_*` after the edge that sampled it.
- Throughput: one instruction per cycle with no stall or redirect.
- Redirect penalty: one bubble. The instruction at the target appears on IF/ID two edges after `redirect` is sampled.
- `stall` and `redirect` are sampled on rising edges only and are level sensitive. `stall` held N cycles gives N held cycles.
- All outputs are registered except `imem_addr`, which is combinational from the PC.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched` (32, count of edges loading `valid` = 1) and `perf_stalls` (32, count of edges with `stall` = 1 and `redirect` = 0). Both counters reset to 0 and wrap modulo 2^32.
- `FETCH_PERF_EN` undefined: neither port nor counter logic exists. Fetch behaviour is identical in both builds.

## Structure
- Shared package `pipeline_pkg`:
  - `NOP_INSTR` = 32'h0.
  - `PC_STEP` = 4.
  - Packed struct `if_id_t` {`instr`, `pc_plus4`, `valid`}, reused by decode.
- One sub-module, `if_id_reg`:
  - Holds `if_id_t`.
  - Inputs: `load`, `squash`, `d`.
  - Squash wins over load; hold when neither is asserted.
  - The PC and next-PC mux stay in `fetch_stage`.

## Test plan
- Reset, then free-run over a memory preloaded with 2001000A, 20020014, 20030032. Expected:
  - `imem_addr` = 0, 4, 8 on successive cycles.
  - `if_id_instr` = 2001000A, 20020014, 20030032.
  - `if_id_pc_plus4` = 4, 8, C.
  - `valid` = 1 from the first edge.
- `stall` high for 3 cycles while PC = 8 → PC stays 8 and IF/ID holds 20020014/8. Release → 20030032/C.
- `redirect` = 1 with `redirect_target` = 32'h13 while PC = 1C → next edge gives PC = 10 and a bubble (`valid` = 0, `instr` = 0). Following edge gives `if_id_instr` = mem[4], `pc_plus4` = 14.
- `redirect` and `stall` high together → redirect applies: PC loads the target and IF/ID is bubbled.
- Run past 0xFC with `IMEM_WORDS` = 64 → at PC = 0x100, PC holds, bubbles repeat and `fetch_fault` = 1. Redirect to 0 → fetch resumes with `fetch_fault` still 1.
- Assert `rst_n` low mid-redirect → all outputs reach reset values before the next edge. With `FETCH_PERF_EN`, 5 fetches and 2 stalls read back as `perf_fetched` = 5 and `perf_stalls` = 2.
